// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the uP pipeline hazard/control-flow sequencer.
// PC mux encodings, counter defaults and the per-cycle control decision type.
package pipe_ctrl_pkg;

    localparam logic [1:0] PC_SEL_NEXT = 2'd0;
    localparam logic [1:0] PC_SEL_JMP  = 2'd1;
    localparam logic [1:0] PC_SEL_BR   = 2'd2;

    localparam int unsigned CNT_WIDTH_DEF = 16;
    localparam int unsigned BR_OFF_WIDTH  = 6;

    // Winning action for the current cycle, highest priority first in the decode
    typedef enum logic [1:0] {
        CTL_RUN,
        CTL_STALL,
        CTL_JUMP,
        CTL_BRANCH
    } ctl_mode_e;

endpackage

// File: rtl/pipe_scoreboard.sv
// One pending-write shift chain (bit 0 = EX ... DEPTH-1 = WB) for a single register.
// A bubble entering EX forces bit 0 to zero regardless of the load request.
module pipe_scoreboard #(
    parameter int unsigned DEPTH = 3
) (
    input  logic Clock,
    input  logic Reset,
    input  logic iLoad,
    input  logic iInject,
    output logic oAnyPending
);

    logic [DEPTH-1:0] r_chain;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[DEPTH-2:0], iLoad & ~iInject};
        end
    end

    // WB entry still counts: the register file write lands after ID has read
    assign oAnyPending = |r_chain;

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard and control-flow sequencer for the 5-stage uP pipeline: stalls IF/ID on
// in-flight register reads, redirects the PC for jumps (ID) and taken branches (EX).
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned PC_WIDTH  = 10,
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF,
    parameter int unsigned SB_DEPTH  = 3
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    iValidID,
    input  logic [PC_WIDTH-1:0]     iPcID,
    input  logic                    iWrA_ID,
    input  logic                    iWrB_ID,
    input  logic                    iRdA_ID,
    input  logic                    iRdB_ID,
    input  logic                    iJmpEnableID,
    input  logic [PC_WIDTH-1:0]     iJmpDirID,
    input  logic                    iBranchEnableID,
    input  logic [BR_OFF_WIDTH-1:0] iBranchDirID,
    input  logic                    iBranchTakenEX,
    output logic                    oPcEnable,
    output logic [1:0]              oPcSel,
    output logic [PC_WIDTH-1:0]     oPcTarget,
    output logic                    oIfIdEnable,
    output logic                    oIfIdFlush,
    output logic                    oIdExBubble,
    output logic                    oBranchPendingEX,
    output logic [CNT_WIDTH-1:0]    oStallCount,
    output logic [CNT_WIDTH-1:0]    oFlushCount
);

    logic                 w_pendA;
    logic                 w_pendB;
    logic                 w_hz;
    logic                 w_takenBr;
    logic                 w_jmp;
    logic                 w_inject;
    logic                 w_brLoad;
    logic [PC_WIDTH-1:0]  w_brOff;
    ctl_mode_e            w_mode;

    logic                 r_brPend;
    logic [PC_WIDTH-1:0]  r_brTgt;
    logic [CNT_WIDTH-1:0] r_stallCnt;
    logic [CNT_WIDTH-1:0] r_flushCnt;

    pipe_scoreboard #(.DEPTH(SB_DEPTH)) u_sb_a (
        .Clock       (Clock),
        .Reset       (Reset),
        .iLoad       (iValidID & iWrA_ID),
        .iInject     (w_inject),
        .oAnyPending (w_pendA)
    );

    pipe_scoreboard #(.DEPTH(SB_DEPTH)) u_sb_b (
        .Clock       (Clock),
        .Reset       (Reset),
        .iLoad       (iValidID & iWrB_ID),
        .iInject     (w_inject),
        .oAnyPending (w_pendB)
    );

    assign w_hz      = iValidID & ((iRdA_ID & w_pendA) | (iRdB_ID & w_pendB));
    assign w_takenBr = r_brPend & iBranchTakenEX;
    assign w_jmp     = iValidID & iJmpEnableID;

    always_comb begin
        w_mode = CTL_RUN;
        if (w_takenBr) begin
            w_mode = CTL_BRANCH;
        end else if (w_hz) begin
            w_mode = CTL_STALL;
        end else if (w_jmp) begin
            w_mode = CTL_JUMP;
        end
    end

    always_comb begin
        oPcEnable   = 1'b1;
        oPcSel      = PC_SEL_NEXT;
        oPcTarget   = '0;
        oIfIdEnable = 1'b1;
        oIfIdFlush  = 1'b0;
        oIdExBubble = 1'b0;
        case (w_mode)
            CTL_BRANCH: begin
                oPcSel      = PC_SEL_BR;
                oPcTarget   = r_brTgt;
                oIfIdFlush  = 1'b1;
                oIdExBubble = 1'b1;
            end
            CTL_STALL: begin
                oPcEnable   = 1'b0;
                oIfIdEnable = 1'b0;
                oIdExBubble = 1'b1;
            end
            CTL_JUMP: begin
                oPcSel     = PC_SEL_JMP;
                oPcTarget  = iJmpDirID;
                oIfIdFlush = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // A branch enters EX only if the ID instruction actually advances this cycle
    assign w_inject = oIdExBubble;
    assign w_brLoad = iValidID & iBranchEnableID & ~w_inject;
    assign w_brOff  = {{(PC_WIDTH-BR_OFF_WIDTH){iBranchDirID[BR_OFF_WIDTH-1]}}, iBranchDirID};

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_brPend <= 1'b0;
            r_brTgt  <= '0;
        end else begin
            r_brPend <= w_brLoad;
            if (w_brLoad) begin
                r_brTgt <= iPcID + w_brOff;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            if (w_mode == CTL_STALL && r_stallCnt != '1) begin
                r_stallCnt <= r_stallCnt + CNT_WIDTH'(1);
            end
            if ((w_mode == CTL_BRANCH || w_mode == CTL_JUMP) && r_flushCnt != '1) begin
                r_flushCnt <= r_flushCnt + CNT_WIDTH'(1);
            end
        end
    end

    assign oBranchPendingEX = r_brPend;
    assign oStallCount      = r_stallCnt;
    assign oFlushCount      = r_flushCnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vector table, hand sequences for
// reset and counter saturation, then random stimulus against a behavioural model.
module tb_pipe_ctrl;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic       Reset;
    logic       iValidID;
    logic [9:0] iPcID;
    logic       iWrA_ID, iWrB_ID, iRdA_ID, iRdB_ID;
    logic       iJmpEnableID;
    logic [9:0] iJmpDirID;
    logic       iBranchEnableID;
    logic [5:0] iBranchDirID;
    logic       iBranchTakenEX;
    logic       oPcEnable;
    logic [1:0] oPcSel;
    logic [9:0] oPcTarget;
    logic       oIfIdEnable, oIfIdFlush, oIdExBubble, oBranchPendingEX;
    logic [15:0] oStallCount, oFlushCount;

    // small-counter instance used only for saturation
    logic       s_Reset, s_v, s_wa, s_ra, s_j;
    logic       s_pcEn, s_ifEn, s_fl, s_bub, s_bp;
    logic [1:0] s_sel;
    logic [9:0] s_tgt;
    logic [2:0] s_sc, s_fc;

    int errors = 0;
    int checks = 0;

    pipe_ctrl #(.PC_WIDTH(10), .CNT_WIDTH(16), .SB_DEPTH(3)) dut (
        .Clock(Clock), .Reset(Reset), .iValidID(iValidID), .iPcID(iPcID),
        .iWrA_ID(iWrA_ID), .iWrB_ID(iWrB_ID), .iRdA_ID(iRdA_ID), .iRdB_ID(iRdB_ID),
        .iJmpEnableID(iJmpEnableID), .iJmpDirID(iJmpDirID),
        .iBranchEnableID(iBranchEnableID), .iBranchDirID(iBranchDirID),
        .iBranchTakenEX(iBranchTakenEX), .oPcEnable(oPcEnable), .oPcSel(oPcSel),
        .oPcTarget(oPcTarget), .oIfIdEnable(oIfIdEnable), .oIfIdFlush(oIfIdFlush),
        .oIdExBubble(oIdExBubble), .oBranchPendingEX(oBranchPendingEX),
        .oStallCount(oStallCount), .oFlushCount(oFlushCount)
    );

    pipe_ctrl #(.PC_WIDTH(10), .CNT_WIDTH(3), .SB_DEPTH(3)) dut_sat (
        .Clock(Clock), .Reset(s_Reset), .iValidID(s_v), .iPcID(10'h000),
        .iWrA_ID(s_wa), .iWrB_ID(1'b0), .iRdA_ID(s_ra), .iRdB_ID(1'b0),
        .iJmpEnableID(s_j), .iJmpDirID(10'h123),
        .iBranchEnableID(1'b0), .iBranchDirID(6'h00),
        .iBranchTakenEX(1'b0), .oPcEnable(s_pcEn), .oPcSel(s_sel),
        .oPcTarget(s_tgt), .oIfIdEnable(s_ifEn), .oIfIdFlush(s_fl),
        .oIdExBubble(s_bub), .oBranchPendingEX(s_bp),
        .oStallCount(s_sc), .oFlushCount(s_fc)
    );

    typedef struct {
        logic v; logic [9:0] pc; logic wa, wb, ra, rb, j; logic [9:0] jd;
        logic b; logic [5:0] bd; logic tk;
        logic pen; logic [1:0] sel; logic [9:0] tgt; logic ifen, fl, bub, bp;
        int sc, fc;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(int v, int pc, int wa, int wb, int ra, int rb, int j,
                                int jd, int b, int bd, int tk, int pen, int sel, int tgt,
                                int ifen, int fl, int bub, int bp, int sc, int fc);
        vec_t r;
        r.v = 1'(v); r.pc = 10'(pc); r.wa = 1'(wa); r.wb = 1'(wb); r.ra = 1'(ra);
        r.rb = 1'(rb); r.j = 1'(j); r.jd = 10'(jd); r.b = 1'(b); r.bd = 6'(bd);
        r.tk = 1'(tk); r.pen = 1'(pen); r.sel = 2'(sel); r.tgt = 10'(tgt);
        r.ifen = 1'(ifen); r.fl = 1'(fl); r.bub = 1'(bub); r.bp = 1'(bp);
        r.sc = sc; r.fc = fc;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int pen, input int sel, input int tgt,
                           input int ifen, input int fl, input int bub, input int bp,
                           input int sc, input int fc);
        chk({tag, " pcEn"},    32'(oPcEnable),        pen);
        chk({tag, " pcSel"},   32'(oPcSel),           sel);
        chk({tag, " pcTgt"},   32'(oPcTarget),        tgt);
        chk({tag, " ifIdEn"},  32'(oIfIdEnable),      ifen);
        chk({tag, " flush"},   32'(oIfIdFlush),       fl);
        chk({tag, " bubble"},  32'(oIdExBubble),      bub);
        chk({tag, " brPend"},  32'(oBranchPendingEX), bp);
        chk({tag, " stalls"},  32'(oStallCount),      sc);
        chk({tag, " flushes"}, 32'(oFlushCount),      fc);
    endtask

    task automatic idle_inputs();
        iValidID = 0; iPcID = '0; iWrA_ID = 0; iWrB_ID = 0; iRdA_ID = 0; iRdB_ID = 0;
        iJmpEnableID = 0; iJmpDirID = '0; iBranchEnableID = 0; iBranchDirID = '0;
        iBranchTakenEX = 0;
    endtask

    task automatic sat_stall_round();
        @(negedge Clock); s_v = 1; s_wa = 1; s_ra = 0;
        @(negedge Clock); s_wa = 0; s_ra = 1;
        @(negedge Clock);
        @(negedge Clock);
        @(negedge Clock); s_v = 0; s_ra = 0;
        #1;
    endtask

    // behavioural reference: remaining in-flight cycles per register, branch slot, counts
    int m_pendA, m_pendB, m_brTgt, m_sc, m_fc;
    bit m_brPend;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        bit tkb, hz, jp, rst_now;
        int e_pen, e_sel, e_tgt, e_ifen, e_fl, e_bub;

        tbl[0]  = mk(1,'h00F,1,0,0,0,0,0,    0,0,   0, 1,0,0,    1,0,0,0, 0,0);
        tbl[1]  = mk(1,'h00F,0,0,1,0,0,0,    0,0,   0, 0,0,0,    0,0,1,0, 0,0);
        tbl[2]  = mk(1,'h00F,0,0,1,0,0,0,    0,0,   0, 0,0,0,    0,0,1,0, 1,0);
        tbl[3]  = mk(1,'h00F,0,0,1,0,0,0,    0,0,   0, 0,0,0,    0,0,1,0, 2,0);
        tbl[4]  = mk(1,'h010,0,0,1,0,0,0,    1,'h3E,0, 1,0,0,    1,0,0,0, 3,0);
        tbl[5]  = mk(1,'h011,0,0,0,0,0,0,    0,0,   1, 1,2,'h00E,1,1,1,1, 3,0);
        tbl[6]  = mk(0,0,    0,0,0,0,0,0,    0,0,   1, 1,0,0,    1,0,0,0, 3,1);
        tbl[7]  = mk(1,'h012,0,0,0,0,1,'h3FF,0,0,   0, 1,1,'h3FF,1,1,0,0, 3,1);
        tbl[8]  = mk(0,0,    0,0,0,0,0,0,    0,0,   0, 1,0,0,    1,0,0,0, 3,2);
        tbl[9]  = mk(1,'h020,0,1,0,0,0,0,    0,0,   0, 1,0,0,    1,0,0,0, 3,2);
        tbl[10] = mk(1,'h021,0,0,0,0,0,0,    1,'h05,0, 1,0,0,    1,0,0,0, 3,2);
        tbl[11] = mk(1,'h022,0,0,0,1,1,'h100,0,0,   1, 1,2,'h026,1,1,1,1, 3,2);
        tbl[12] = mk(1,'h030,1,0,0,0,0,0,    0,0,   0, 1,0,0,    1,0,0,0, 3,3);
        tbl[13] = mk(1,'h031,0,0,1,0,1,'h055,0,0,   0, 0,0,0,    0,0,1,0, 3,3);
        tbl[14] = mk(1,'h031,0,0,1,0,1,'h055,0,0,   0, 0,0,0,    0,0,1,0, 4,3);
        tbl[15] = mk(1,'h031,0,0,1,0,1,'h055,0,0,   0, 0,0,0,    0,0,1,0, 5,3);
        tbl[16] = mk(1,'h031,0,0,1,0,1,'h055,0,0,   0, 1,1,'h055,1,1,0,0, 6,3);
        tbl[17] = mk(0,0,    0,0,0,0,0,0,    0,0,   0, 1,0,0,    1,0,0,0, 6,4);

        idle_inputs();
        Reset = 0; s_Reset = 0; s_v = 0; s_wa = 0; s_ra = 0; s_j = 0;
        #1;
        chk_all("reset", 1, 0, 0, 1, 0, 0, 0, 0, 0);
        @(negedge Clock); Reset = 1; s_Reset = 1;

        for (int i = 0; i < 18; i++) begin
            @(negedge Clock);
            iValidID = tbl[i].v; iPcID = tbl[i].pc; iWrA_ID = tbl[i].wa;
            iWrB_ID = tbl[i].wb; iRdA_ID = tbl[i].ra; iRdB_ID = tbl[i].rb;
            iJmpEnableID = tbl[i].j; iJmpDirID = tbl[i].jd;
            iBranchEnableID = tbl[i].b; iBranchDirID = tbl[i].bd;
            iBranchTakenEX = tbl[i].tk;
            #1;
            chk_all($sformatf("row%0d", i), tbl[i].pen, tbl[i].sel, tbl[i].tgt,
                    tbl[i].ifen, tbl[i].fl, tbl[i].bub, tbl[i].bp, tbl[i].sc, tbl[i].fc);
        end

        // reset asserted mid-stall, away from any clock edge
        @(negedge Clock); idle_inputs(); iValidID = 1; iWrA_ID = 1;
        @(negedge Clock); iWrA_ID = 0; iRdA_ID = 1;
        #1;
        chk("midrst stall pcEn", 32'(oPcEnable), 0);
        #2; Reset = 0;
        #1;
        chk_all("midrst", 1, 0, 0, 1, 0, 0, 0, 0, 0);
        @(negedge Clock); Reset = 1; idle_inputs();
        #1;
        chk_all("postrst", 1, 0, 0, 1, 0, 0, 0, 0, 0);

        // saturation on the 3-bit instance: 6 = all-ones minus one, then stays at 7
        sat_stall_round();
        sat_stall_round();
        chk("sat stalls 6", 32'(s_sc), 6);
        sat_stall_round();
        chk("sat stalls 7", 32'(s_sc), 7);
        sat_stall_round();
        chk("sat stalls hold", 32'(s_sc), 7);
        @(negedge Clock); s_v = 1; s_j = 1;
        #1;
        chk("sat jmp sel", 32'(s_sel), 1);
        chk("sat jmp tgt", 32'(s_tgt), 'h123);
        repeat (9) @(negedge Clock);
        s_v = 0; s_j = 0;
        #1;
        chk("sat flushes 7", 32'(s_fc), 7);

        // random stimulus against the reference model
        @(negedge Clock); Reset = 0; idle_inputs();
        m_pendA = 0; m_pendB = 0; m_brTgt = 0; m_brPend = 0; m_sc = 0; m_fc = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge Clock);
            rst_now = ($urandom_range(0, 199) == 0);
            Reset = rst_now ? 1'b0 : 1'b1;
            if (rst_now) begin
                m_pendA = 0; m_pendB = 0; m_brTgt = 0; m_brPend = 0; m_sc = 0; m_fc = 0;
            end
            iValidID        = ($urandom_range(0, 9) != 0);
            iPcID           = 10'($urandom);
            iWrA_ID         = ($urandom_range(0, 9) < 3);
            iWrB_ID         = ($urandom_range(0, 9) < 3);
            iRdA_ID         = ($urandom_range(0, 9) < 3);
            iRdB_ID         = ($urandom_range(0, 9) < 3);
            iJmpEnableID    = ($urandom_range(0, 19) < 3);
            iJmpDirID       = 10'($urandom);
            iBranchEnableID = ($urandom_range(0, 4) == 0);
            iBranchDirID    = 6'($urandom);
            iBranchTakenEX  = 1'($urandom);
            #1;
            tkb = m_brPend && iBranchTakenEX;
            hz  = iValidID && ((iRdA_ID && m_pendA > 0) || (iRdB_ID && m_pendB > 0));
            jp  = iValidID && iJmpEnableID;
            if (tkb) begin
                e_pen = 1; e_sel = 2; e_tgt = m_brTgt; e_ifen = 1; e_fl = 1; e_bub = 1;
            end else if (hz) begin
                e_pen = 0; e_sel = 0; e_tgt = 0; e_ifen = 0; e_fl = 0; e_bub = 1;
            end else if (jp) begin
                e_pen = 1; e_sel = 1; e_tgt = int'(iJmpDirID); e_ifen = 1; e_fl = 1; e_bub = 0;
            end else begin
                e_pen = 1; e_sel = 0; e_tgt = 0; e_ifen = 1; e_fl = 0; e_bub = 0;
            end
            chk_all($sformatf("rand%0d", n), e_pen, e_sel, e_tgt, e_ifen, e_fl, e_bub,
                    int'(m_brPend), m_sc, m_fc);
            if (!rst_now) begin
                m_pendA = (m_pendA > 0) ? m_pendA - 1 : 0;
                m_pendB = (m_pendB > 0) ? m_pendB - 1 : 0;
                if (!tkb && !hz && iValidID) begin
                    if (iWrA_ID) m_pendA = 3;
                    if (iWrB_ID) m_pendB = 3;
                end
                m_brPend = iValidID && iBranchEnableID && !tkb && !hz;
                if (m_brPend)
                    m_brTgt = (int'(iPcID) + int'($signed(iBranchDirID))) & 'h3FF;
                if (hz && !tkb && m_sc < 65535) m_sc++;
                if ((tkb || (jp && !hz)) && m_fc < 65535) m_fc++;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Hazard and control-flow sequencer for the 5-stage `uP` pipeline (IF/ID/EX/ME/WB). It tracks pending writes to registers A and B and stalls IF/ID when an instruction in ID reads a register that is still in flight. It redirects the PC for jumps, resolved in ID, and for taken branches, resolved in EX, and flushes wrong-path stages. It sits beside the pipeline registers and drives their enables and flushes plus the PC mux select.

## Interface
Parameters:
- PC_WIDTH, 10, PC/address width
- CNT_WIDTH, 16, performance counter width
- SB_DEPTH, 3, scoreboard depth (EX, ME, WB)

Ports:
- Clock  in  1  single clock, rising edge
- Reset  in  1  asynchronous, active-low; clears all state immediately
- iValidID  in  1  ID holds a real instruction (not a bubble)
- iPcID  in  PC_WIDTH  PC of the instruction in ID
- iWrA_ID, iWrB_ID  in  1  ID instruction writes A / B (selA/selB ≠ 0)
- iRdA_ID, iRdB_ID  in  1  ID instruction reads A / B (including flags for branch)
- iJmpEnableID  in  1  ID instruction is a jump
- iJmpDirID  in  PC_WIDTH  absolute jump target
- iBranchEnableID  in  1  ID instruction is a conditional branch
- iBranchDirID  in  6  signed branch offset
- iBranchTakenEX  in  1  branch condition result; sampled only while oBranchPendingEX=1
- oPcEnable  out  1  PC register enable
- oPcSel  out  2  0=PC+1, 1=jump, 2=branch, 3 unused
- oPcTarget  out  PC_WIDTH  redirect target
- oIfIdEnable  out  1  IF/ID register enable
- oIfIdFlush  out  1  load IF/ID with a zero (bubble) instruction
- oIdExBubble  out  1  load ID/EX with zero controls
- oBranchPendingEX  out  1  a branch currently occupies EX
- oStallCount, oFlushCount  out  CNT_WIDTH  saturating event counters

## Operation
- Scoreboard: per-register shift chains sbA, sbB[SB_DEPTH-1:0]; index 0=EX, 1=ME, 2=WB. Each cycle they shift toward WB.
  - Entry 0 loads iValidID&iWrA_ID (resp. B).
  - Entry 0 loads 0 when a bubble is injected.
- Data hazard: hz = iValidID & ((iRdA_ID & |sbA) | (iRdB_ID & |sbB)). A WB-stage write is visible to ID only on the next cycle, so the WB entry counts as pending.
- Branch register: on ID→EX advance with iValidID&iBranchEnableID and no hazard/flush:
  - brPend ← 1
  - brTgt ← iPcID + sign-extended iBranchDirID, modulo 2^PC_WIDTH
  - Otherwise brPend ← 0.
- Priority, evaluated each cycle:
  1. takenBr = brPend & iBranchTakenEX: oPcSel=2, oPcTarget=brTgt, oIfIdFlush=1, oIdExBubble=1, oPcEnable=1, oIfIdEnable=1. The ID instruction is killed even if hazarded or a jump.
  2. hz: oPcEnable=0, oIfIdEnable=0, oIdExBubble=1, oPcSel=0.
  3. jmp = iValidID & iJmpEnableID: oPcSel=1, oPcTarget=iJmpDirID, oIfIdFlush=1; ID/EX advances normally.
  4. Else RUN: all enables 1, flush/bubble 0, oPcSel=0.
- oPcTarget=0 when oPcSel=0.
- Counters:
  - oStallCount increments on each hz cycle not overridden by takenBr.
  - oFlushCount increments by 1 on each takenBr or jmp cycle.
  - Both saturate at all-ones.
- oBranchPendingEX = brPend.

## Timing
- Reset (async, low) clears sbA, sbB, brPend, brTgt and both counters. Resulting outputs: oPcSel=0, oPcTarget=0, oPcEnable=1, oIfIdEnable=1, flush/bubble=0, counters=0.
- All outputs are combinational from registered state plus current ID/EX inputs. The pipeline registers act on the following rising edge.
- Redirect cost: jump costs 1 bubble; taken branch costs 2 bubbles; not-taken branch costs 0.
- Stall length equals cycles until the producing entry leaves WB: producer in EX costs 3 stall cycles, ME 2, WB 1.
- Simultaneous events:
  - takenBr and a jump in ID: branch wins, jump discarded.
  - Hazard and jump in the same instruction: stall first; the jump redirects on the release cycle.
- Reset asserted mid-stall or mid-redirect: state is cleared immediately. The pipeline restarts sequential fetch after release.

## Structure
- Shared package: PC_SEL_NEXT=0, PC_SEL_JMP=1, PC_SEL_BR=2 constants; CNT_WIDTH default.
- One natural sub-module: `pipe_scoreboard` (one parameterised chain, instantiated for A and B, with inject-zero control and an any-pending output).

## Test plan
- Reset low mid-run → all outputs at reset values within the same cycle; counters 0.
- Producer writes A (EX), next ID instruction reads A → oPcEnable=0 for exactly 3 cycles, oIdExBubble=1 each cycle, oStallCount=3.
- iPcID=0x010, branch offset 6'h3E (−2), iBranchTakenEX=1 next cycle → oPcSel=2, oPcTarget=0x00E, oIfIdFlush=oIdExBubble=1 for one cycle, oFlushCount=1.
- Jump to 0x3FF in ID with no hazard → oPcSel=1, oPcTarget=0x3FF, oIfIdFlush=1, ID/EX not bubbled.
- Taken branch in EX while ID holds a hazarded jump → branch target selected, no stall counted, jump discarded.
- Force the counter to 0xFFFE, then run 3 stall cycles → oStallCount stays 0xFFFF.
